// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - button debounce, 1 Hz enable and time-set FSM for the BCD time-of-day counter
// Optional macro AUTO_REPEAT_EN: held inc button repeats every REPEAT_CYCLES cycles in SET states.

module clock_set_ctrl #(
  parameter int TICK_DIV      = 50000000,
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       cur_H1,
  input  logic [3:0] cur_H2,
  input  logic [2:0] cur_M1,
  input  logic [3:0] cur_M2,
  input  logic [2:0] cur_S1,
  input  logic [3:0] cur_S2,
  output logic       tick_en,
  output logic       load,
  output logic       set_H1,
  output logic [3:0] set_H2,
  output logic [2:0] set_M1,
  output logic [3:0] set_M2,
  output logic [2:0] set_S1,
  output logic [3:0] set_S2,
  output logic [1:0] mode
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RUN, S_SET_H, S_SET_M, S_SET_S, S_LOAD
  } state_t;

  if (TICK_DIV < 2 || DEB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("clock_set_ctrl: parameter out of range");
  end

  // Index 0 is the mode button, index 1 the inc button.
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       level_q, level_d, press_q, press_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic [DIV_W-1:0] div_q, div_d;
  state_t           state_q, state_d;
  logic             h1_q, h1_d;
  logic [3:0]       h2_q, h2_d, m2_q, m2_d, s2_q, s2_d;
  logic [2:0]       m1_q, m1_d, s1_q, s1_d;
  logic             inc_evt;

  // Level is accepted after DEB_CYCLES consecutive samples disagreeing with it.
  always_comb begin
    sync1_d      = {btn_inc, btn_mode};
    sync2_d      = sync1_q;
    level_d      = level_q;
    deb_cnt_d[0] = '0;
    deb_cnt_d[1] = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) begin
          level_d[b] = sync2_q[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
        end
      end
    end
    press_d = level_d & ~level_q;
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             in_set, rep_pulse;

  always_comb begin
    in_set    = (state_q == S_SET_H) || (state_q == S_SET_M) || (state_q == S_SET_S);
    rep_pulse = in_set && level_q[1] && (press_q == 2'b00) && (rep_q == REP_LAST);
    rep_d     = rep_q + REP_W'(1);
    if (!in_set || !level_q[1] || (press_q != 2'b00) || rep_pulse) begin
      rep_d = '0;
    end
    inc_evt = press_q[1] | rep_pulse;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  always_comb inc_evt = press_q[1];
`endif

  always_comb begin
    div_d   = '0;
    tick_en = 1'b0;
    if (state_q == S_RUN) begin
      if (div_q == DIV_LAST) tick_en = 1'b1;
      else                   div_d   = div_q + DIV_W'(1);
    end
  end

  // Mode press has priority; an inc press in the same cycle is dropped.
  always_comb begin
    state_d = state_q;
    h1_d = h1_q; h2_d = h2_q;
    m1_d = m1_q; m2_d = m2_q;
    s1_d = s1_q; s2_d = s2_q;
    load = 1'b0;
    mode = 2'd0;
    case (state_q)
      S_RUN: begin
        if (press_q[0]) begin
          h1_d = cur_H1; h2_d = cur_H2;
          m1_d = cur_M1; m2_d = cur_M2;
          s1_d = cur_S1; s2_d = cur_S2;
          state_d = S_SET_H;
        end
      end
      S_SET_H: begin
        mode = 2'd1;
        if (press_q[0]) begin
          state_d = S_SET_M;
        end else if (inc_evt) begin
          if (h2_q == 4'd9) begin
            h2_d = 4'd0;
            h1_d = ~h1_q;
          end else begin
            h2_d = h2_q + 4'd1;
          end
        end
      end
      S_SET_M: begin
        mode = 2'd2;
        if (press_q[0]) begin
          state_d = S_SET_S;
        end else if (inc_evt) begin
          if (m2_q == 4'd9) begin
            m2_d = 4'd0;
            m1_d = (m1_q == 3'd5) ? 3'd0 : m1_q + 3'd1;
          end else begin
            m2_d = m2_q + 4'd1;
          end
        end
      end
      S_SET_S: begin
        mode = 2'd3;
        if (press_q[0]) begin
          state_d = S_LOAD;
        end else if (inc_evt) begin
          s1_d = 3'd0;
          s2_d = 4'd0;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      press_q      <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      div_q        <= '0;
      state_q      <= S_RUN;
      h1_q <= 1'b0; h2_q <= '0;
      m1_q <= '0;   m2_q <= '0;
      s1_q <= '0;   s2_q <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      press_q      <= press_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      div_q        <= div_d;
      state_q      <= state_d;
      h1_q <= h1_d; h2_q <= h2_d;
      m1_q <= m1_d; m2_q <= m2_d;
      s1_q <= s1_d; s2_q <= s2_d;
    end
  end

  assign set_H1 = h1_q;
  assign set_H2 = h2_q;
  assign set_M1 = m1_q;
  assign set_M2 = m2_q;
  assign set_S1 = s1_q;
  assign set_S2 = s2_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed table-driven bench for clock_set_ctrl
// Expected auto-repeat result follows AUTO_REPEAT_EN as defined for the build.

module tb_clock_set_ctrl;
  localparam int TICK_DIV      = 10;
  localparam int DEB_CYCLES    = 4;
  localparam int REPEAT_CYCLES = 20;

  typedef logic [18:0] tod_t;  // {H1,H2,M1,M2,S1,S2}

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc;
  logic       cur_H1, set_H1;
  logic [3:0] cur_H2, cur_M2, cur_S2, set_H2, set_M2, set_S2;
  logic [2:0] cur_M1, cur_S1, set_M1, set_S1;
  logic       tick_en, load;
  logic [1:0] mode;
  tod_t       set_all;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_H1(cur_H1), .cur_H2(cur_H2), .cur_M1(cur_M1),
    .cur_M2(cur_M2), .cur_S1(cur_S1), .cur_S2(cur_S2),
    .tick_en(tick_en), .load(load),
    .set_H1(set_H1), .set_H2(set_H2), .set_M1(set_M1),
    .set_M2(set_M2), .set_S1(set_S1), .set_S2(set_S2),
    .mode(mode)
  );

  assign set_all = {set_H1, set_H2, set_M1, set_M2, set_S1, set_S2};

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int tick_load_viol = 0;

  always @(negedge clk) begin
    if (load) load_cnt <= load_cnt + 1;
    if (load && tick_en) tick_load_viol <= tick_load_viol + 1;
  end

  function automatic tod_t tod(int h1, int h2, int m1, int m2, int s1, int s2);
    return {1'(h1), 4'(h2), 3'(m1), 4'(m2), 3'(s1), 4'(s2)};
  endfunction

  function automatic string fmt(tod_t v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", v[18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tod(input string name, input tod_t act, input tod_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic set_cur(input tod_t v);
    {cur_H1, cur_H2, cur_M1, cur_M2, cur_S1, cur_S2} = v;
  endtask

  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (8) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    bit   bm;
    bit   bi;
    tod_t cur;
    int   exp_mode;
    tod_t exp_set;
    int   exp_loads;
  } vec_t;

  vec_t vecs[20];

  initial begin
    tod_t c1, c2, c3, z;
    bit   found;
    int   n, l0, exp_m2;

    c1 = tod(1, 2, 3, 4, 5, 6);
    c2 = tod(1, 9, 5, 9, 5, 8);
    c3 = tod(0, 9, 0, 5, 0, 7);
    z  = '0;
    vecs[0]  = '{1'b0, 1'b1, c1, 1, tod(1, 3, 3, 4, 5, 6), 0};
    vecs[1]  = '{1'b1, 1'b0, c1, 2, tod(1, 3, 3, 4, 5, 6), 0};
    vecs[2]  = '{1'b0, 1'b1, c1, 2, tod(1, 3, 3, 5, 5, 6), 0};
    vecs[3]  = '{1'b1, 1'b0, c1, 3, tod(1, 3, 3, 5, 5, 6), 0};
    vecs[4]  = '{1'b0, 1'b1, c1, 3, tod(1, 3, 3, 5, 0, 0), 0};
    vecs[5]  = '{1'b1, 1'b0, c1, 0, tod(1, 3, 3, 5, 0, 0), 1};
    vecs[6]  = '{1'b0, 1'b1, c2, 0, tod(1, 3, 3, 5, 0, 0), 1};
    vecs[7]  = '{1'b1, 1'b0, c2, 1, c2,                    1};
    vecs[8]  = '{1'b0, 1'b1, c2, 1, tod(0, 0, 5, 9, 5, 8), 1};
    vecs[9]  = '{1'b1, 1'b0, c2, 2, tod(0, 0, 5, 9, 5, 8), 1};
    vecs[10] = '{1'b0, 1'b1, c2, 2, tod(0, 0, 0, 0, 5, 8), 1};
    vecs[11] = '{1'b1, 1'b0, c2, 3, tod(0, 0, 0, 0, 5, 8), 1};
    vecs[12] = '{1'b1, 1'b0, c2, 0, tod(0, 0, 0, 0, 5, 8), 2};
    vecs[13] = '{1'b1, 1'b0, c3, 1, c3,                    2};
    vecs[14] = '{1'b0, 1'b1, z,  1, tod(1, 0, 0, 5, 0, 7), 2};
    vecs[15] = '{1'b0, 1'b1, z,  1, tod(1, 1, 0, 5, 0, 7), 2};
    vecs[16] = '{1'b1, 1'b1, z,  2, tod(1, 1, 0, 5, 0, 7), 2};
    vecs[17] = '{1'b0, 1'b1, z,  2, tod(1, 1, 0, 6, 0, 7), 2};
    vecs[18] = '{1'b1, 1'b0, z,  3, tod(1, 1, 0, 6, 0, 7), 2};
    vecs[19] = '{1'b1, 1'b0, z,  0, tod(1, 1, 0, 6, 0, 7), 3};

    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    set_cur(z);
    repeat (3) @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_load", load, 0);
    check("rst_tick", tick_en, 0);
    check_tod("rst_set", set_all, z);

    // Cycle 1 is the one in which reset drops.
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", c), tick_en, (c % TICK_DIV == 0) ? 1 : 0);
    end
    check("run_mode", mode, 0);
    check("run_no_load", load_cnt, 0);

    @(negedge clk); btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_mode", mode, 0);

    set_cur(c1);
    @(negedge clk); btn_mode = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == DEB_CYCLES + 1) check("press_edge_k5_mode", mode, 0);
      if (j == DEB_CYCLES + 2) begin
        check("press_edge_k6_mode", mode, 1);
        check_tod("snapshot", set_all, c1);
      end
    end
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);

    for (int v = 0; v < 20; v++) begin
      set_cur(vecs[v].cur);
      press(vecs[v].bm, vecs[v].bi);
      check($sformatf("vec%0d_mode", v), mode, vecs[v].exp_mode);
      check_tod($sformatf("vec%0d_set", v), set_all, vecs[v].exp_set);
      check($sformatf("vec%0d_loads", v), load_cnt, vecs[v].exp_loads);
    end

    set_cur(tod(1, 5, 4, 2, 3, 1));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("seq_load_in_set_s", mode, 3);
    l0 = load_cnt;
    @(negedge clk); btn_mode = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (load) found = 1'b1;
    end
    btn_mode = 1'b0;
    check("load_seen", found, 1);
    check("load_cycle_mode", mode, 0);
    check("load_cycle_tick", tick_en, 0);
    check_tod("load_cycle_set", set_all, tod(1, 5, 4, 2, 3, 1));
    n = 0;
    found = 1'b0;
    while (n < 3 * TICK_DIV && !found) begin
      @(negedge clk);
      n++;
      if (n == 1) check("load_one_cycle", load, 0);
      if (tick_en) found = 1'b1;
    end
    check("first_tick_after_load", n, TICK_DIV);
    check("load_pulse_count", load_cnt - l0, 1);
    repeat (12) @(negedge clk);

    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_reset_mode", mode, 2);
    l0 = load_cnt;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_mode", mode, 0);
    check("mid_reset_load", load, 0);
    check_tod("mid_reset_set", set_all, z);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_no_load", load_cnt - l0, 0);
    check("post_reset_mode", mode, 0);

    set_cur(tod(1, 2, 0, 0, 0, 0));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("rep_in_set_m", mode, 2);
    @(negedge clk); btn_inc = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (set_M2 != 4'd0) found = 1'b1;
    end
    check("rep_first_inc_seen", found, 1);
    repeat (45) @(negedge clk);
    btn_inc = 1'b0;
    repeat (20) @(negedge clk);
`ifdef AUTO_REPEAT_EN
    exp_m2 = 3;
`else
    exp_m2 = 1;
`endif
    check_tod("held_inc_minutes", set_all, tod(1, 2, 0, exp_m2, 0, 0));

    check("tick_with_load", tick_load_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
